// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: pc_src encodings and default vectors.
package pc_unit_pkg;

    localparam logic [2:0] PCSRC_SEQ    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_JR     = 3'd3;
    localparam logic [2:0] PCSRC_ERET   = 3'd4;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target selection with supervisor-bit and word-alignment masking.
// PC_ALIGN_CHECK_EN: flag jr/eret targets whose low bits are not zero.
module pc_next_mux
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [2:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] jr_target,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] next_pc,
    output logic            target_misaligned
);

    logic [XLEN-1:0] raw_target;
    logic            keep_mode;
    logic            kernel;

    always_comb begin
        kernel     = pc[XLEN-1];
        raw_target = pc_plus_4;
        keep_mode  = 1'b1;
        case (pc_src)
            PCSRC_BRANCH: raw_target = branch_taken ? (pc_plus_4 + (imm << 2)) : pc_plus_4;
            PCSRC_JUMP:   raw_target = {pc_plus_4[XLEN-1:28], jump_index, 2'b00};
            PCSRC_JR: begin
                raw_target = jr_target;
                keep_mode  = 1'b0;
            end
            PCSRC_ERET: begin
                raw_target = epc;
                keep_mode  = 1'b0;
            end
            default:      raw_target = pc_plus_4;
        endcase

        // Sequential flow never changes mode; user jr can never reach kernel space.
        next_pc = {raw_target[XLEN-1:2], 2'b00};
        if (keep_mode)
            next_pc[XLEN-1] = kernel;
        else if (pc_src == PCSRC_JR && !kernel)
            next_pc[XLEN-1] = 1'b0;

`ifdef PC_ALIGN_CHECK_EN
        target_misaligned = (pc_src == PCSRC_JR || pc_src == PCSRC_ERET) && (raw_target[1:0] != 2'b00);
`else
        target_misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter, EPC, interrupt/exception priority and irq_ack for the MIPS core family.
// PC_ALIGN_CHECK_EN: misaligned jr/eret targets raise an exception instead of being masked.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(DEFAULT_IRQ_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEFAULT_EXC_VEC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [2:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] jr_target,
    input  logic            undef_inst,
    input  logic            irq_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic [XLEN-1:0] epc,
    output logic            kernel_mode,
    output logic            flush,
    output logic            irq_ack
);

    logic [XLEN-1:0] mux_pc;
    logic            misaligned;
    logic            irq_pending;
    logic            take_exc;
    logic            take_irq;

    assign kernel_mode = pc[XLEN-1];
    assign pc_plus_4   = pc + XLEN'(4);

    pc_next_mux #(.XLEN(XLEN)) u_next_mux (
        .pc                (pc),
        .pc_plus_4         (pc_plus_4),
        .pc_src            (pc_src),
        .branch_taken      (branch_taken),
        .imm               (imm),
        .jump_index        (jump_index),
        .jr_target         (jr_target),
        .epc               (epc),
        .next_pc           (mux_pc),
        .target_misaligned (misaligned)
    );

    // A user-mode eret ranks below a pending interrupt because it is decided at pc_src level.
    always_comb begin
        take_exc = 1'b0;
        take_irq = 1'b0;
        if (!stall) begin
            if (undef_inst || misaligned)
                take_exc = 1'b1;
            else if (irq_pending && !kernel_mode)
                take_irq = 1'b1;
            else if (pc_src == PCSRC_ERET && !kernel_mode)
                take_exc = 1'b1;
        end
    end

    assign flush = take_exc | take_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_VEC;
            epc         <= '0;
            irq_pending <= 1'b0;
            irq_ack     <= 1'b0;
        end else begin
            irq_ack     <= take_irq;
            irq_pending <= take_irq ? 1'b0 : (irq_pending | irq_req);
            if (!stall) begin
                if (take_exc) begin
                    pc  <= EXC_VEC;
                    epc <= pc_plus_4;
                end else if (take_irq) begin
                    pc  <= IRQ_VEC;
                    epc <= pc;
                end else begin
                    pc  <= mux_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: cycle-by-cycle reference model plus directed literal checks.
module tb_pc_unit;

    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] EXC_V = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pc_src = 3'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] imm = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_target = '0;
    logic        undef_inst = 1'b0;
    logic        irq_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] epc;
    logic        kernel_mode;
    logic        flush;
    logic        irq_ack;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        flush;
        logic        irq;
    } step_t;

    logic [31:0] m_pc = RST_V;
    logic [31:0] m_epc = '0;
    logic        m_pend = 1'b0;
    logic        m_ack = 1'b0;
    step_t       m_r;

    pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm          (imm),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .undef_inst   (undef_inst),
        .irq_req      (irq_req),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .epc          (epc),
        .kernel_mode  (kernel_mode),
        .flush        (flush),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    // What the unit must do this cycle, decided from the architectural rules on plain values.
    function automatic step_t predict(input logic [31:0] p, input logic [31:0] e, input logic pend);
        step_t r;
        logic kern;
        logic bad_align;
        logic [31:0] seq;
        logic [31:0] t;
        kern = p[31];
        seq = p + 32'd4;
        r = '{pc: p, epc: e, flush: 1'b0, irq: 1'b0};
        bad_align = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        bad_align = (pc_src == 3'd3 && jr_target[1:0] != 2'b00) || (pc_src == 3'd4 && e[1:0] != 2'b00);
`endif
        if (stall) return r;
        if (undef_inst || bad_align || (pc_src == 3'd4 && !kern && !(pend && !kern))) begin
            r.pc = EXC_V; r.epc = seq; r.flush = 1'b1;
            return r;
        end
        if (pend && !kern) begin
            r.pc = IRQ_V; r.epc = p; r.flush = 1'b1; r.irq = 1'b1;
            return r;
        end
        if (pc_src == 3'd3) begin
            t = jr_target & 32'hFFFF_FFFC;
            r.pc = kern ? t : (t & 32'h7FFF_FFFF);
            return r;
        end
        if (pc_src == 3'd4) begin
            r.pc = e & 32'hFFFF_FFFC;
            return r;
        end
        if (pc_src == 3'd1 && branch_taken) t = seq + imm * 32'd4;
        else if (pc_src == 3'd2) t = (seq & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        else t = seq;
        t[1:0] = 2'b00;
        t[31] = kern;
        r.pc = t;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = RST_V; m_epc = '0; m_pend = 1'b0; m_ack = 1'b0;
        end else begin
            m_r = predict(m_pc, m_epc, m_pend);
            m_ack = m_r.irq;
            m_pend = m_r.irq ? 1'b0 : (m_pend | irq_req);
            m_pc = m_r.pc;
            m_epc = m_r.epc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        step_t p;
        if (reset === 1'b1) begin
            p = predict(m_pc, m_epc, m_pend);
            checkOutput("cyc_pc", pc, m_pc);
            checkOutput("cyc_pc_plus_4", pc_plus_4, m_pc + 32'd4);
            checkOutput("cyc_epc", epc, m_epc);
            checkOutput("cyc_kernel", {31'd0, kernel_mode}, {31'd0, m_pc[31]});
            checkOutput("cyc_flush", {31'd0, flush}, {31'd0, p.flush});
            checkOutput("cyc_irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
        end
    end

    // target doubles as jr_target, branch imm and (bits 27:2) jump index.
    task automatic applyStimulus(input logic [2:0] src, input logic [31:0] target, input logic tk,
                                 input logic und, input logic irq, input logic stl);
        pc_src = src;
        jr_target = target;
        imm = target;
        jump_index = target[27:2];
        branch_taken = tk;
        undef_inst = und;
        irq_req = irq;
        stall = stl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stepPc(input logic [2:0] src, input logic [31:0] target, input logic tk,
                          input logic und, input logic irq, input logic stl, input logic [31:0] exp_pc,
                          input string name);
        applyStimulus(src, target, tk, und, irq, stl);
        tick();
        checkOutput(name, pc, exp_pc);
    endtask

    initial begin
        #12;
        reset = 1'b1;
        checkOutput("rst_pc", pc, RST_V);
        checkOutput("rst_epc", epc, 32'd0);
        checkOutput("rst_ack", {31'd0, irq_ack}, 32'd0);
        checkOutput("rst_kernel", {31'd0, kernel_mode}, 32'd1);

        stepPc(3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXC_V, "undef_pre_reset");
        checkOutput("undef_epc", epc, 32'h8000_0004);
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_000C, "seq_pre_reset");
        reset = 1'b0;
        #1;
        checkOutput("midrst_pc", pc, RST_V);
        checkOutput("midrst_epc", epc, 32'd0);
        checkOutput("midrst_ack", {31'd0, irq_ack}, 32'd0);
        #2;
        reset = 1'b1;
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, "seq1");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, "seq2");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_000C, "seq3");

        stepPc(3'd3, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, "kernel_jr_user");
        stepPc(3'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00FC, "branch_taken_back");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, "seq_back");
        stepPc(3'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, "branch_not_taken");
        stepPc(3'd2, 32'h0000_01FC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_01FC, "jump");

        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("irq_arrive_noflush", {31'd0, flush}, 32'd0);
        tick();
        checkOutput("irq_arrive_pc", pc, 32'h0000_0200);
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("irq_take_flush", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("irq_vec", pc, IRQ_V);
        checkOutput("irq_epc", epc, 32'h0000_0200);
        checkOutput("irq_ack_pulse", {31'd0, irq_ack}, 32'd1);
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, "after_irq_seq");
        checkOutput("irq_ack_drop", {31'd0, irq_ack}, 32'd0);
        stepPc(3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, "eret_return");
        checkOutput("eret_user", {31'd0, kernel_mode}, 32'd0);

        stepPc(3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXC_V, "undef_to_kernel");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_000C, "k_seq1");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010, "k_seq2");
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("kirq_noflush", {31'd0, flush}, 32'd0);
        tick();
        applyStimulus(3'd3, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("kirq_held_noflush", {31'd0, flush}, 32'd0);
        tick();
        checkOutput("kjr_to_user", pc, 32'h0000_0400);
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_irq_flush", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("held_irq_pc", pc, IRQ_V);
        checkOutput("held_irq_epc", epc, 32'h0000_0400);

        stepPc(3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, "eret_400");
        stepPc(3'd3, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, "user_jr_masked");
        applyStimulus(3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("user_eret_flush", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("user_eret_pc", pc, EXC_V);
        checkOutput("user_eret_epc", epc, 32'h0000_1004);

        stepPc(3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1004, "eret_1004");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1008, "irq_pend_set");
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("exc_over_irq_flush", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("exc_over_irq_pc", pc, EXC_V);
        checkOutput("exc_over_irq_epc", epc, 32'h0000_100C);
        stepPc(3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_100C, "eret_100c");
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("still_pending_flush", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("still_pending_epc", epc, 32'h0000_100C);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("stall_flush", {31'd0, flush}, 32'd0);
            tick();
            checkOutput("stall_pc", pc, IRQ_V);
            checkOutput("stall_ack", {31'd0, irq_ack}, 32'd0);
        end

        stepPc(3'd3, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFC, "jr_user_top");
        applyStimulus(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("link_wrap", pc_plus_4, 32'h8000_0000);
        tick();
        checkOutput("user_wrap", pc, 32'h0000_0000);
        stepPc(3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXC_V, "undef_again");
        stepPc(3'd3, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, "jr_kernel_top");
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, "kernel_wrap");
        stepPc(3'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, "src5_seq");
        stepPc(3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, "src7_seq");
`ifdef PC_ALIGN_CHECK_EN
        stepPc(3'd3, 32'h0000_0402, 1'b0, 1'b0, 1'b0, 1'b0, EXC_V, "jr_misaligned_exc");
        checkOutput("jr_misaligned_epc", epc, 32'h8000_000C);
`else
        stepPc(3'd3, 32'h0000_0402, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, "jr_misaligned_mask");
`endif
        stepPc(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, pc + 32'd4, "tail_seq");
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
